// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Base bit of channel i in a flattened bus of (r+1)-bit duty words.
    function automatic int unsigned duty_slice(input int unsigned i, input int unsigned r = 10);
        return i * (r + 1);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock divider: one tick every dvsr+1 clocks while enabled.
module pwm_prescaler #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] dvsr,
    output logic          tick
);

    logic [DW-1:0] q;
    logic [DW-1:0] q_next;

    // >= so a divisor lowered below the current count recovers next cycle
    always_comb begin
        q_next = q;
        if (!en) begin
            q_next = '0;
        end else if (q >= dvsr) begin
            q_next = '0;
        end else begin
            q_next = q + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    assign tick = en && (q == '0);

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM with shared prescaler/period counter, edge or center aligned,
// double-buffered duty words and per-channel polarity.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned R  = 10,
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic [DW-1:0]     dvsr,
    input  logic [N*(R+1)-1:0] duty,
    input  logic [N-1:0]      duty_wr,
    input  logic [N-1:0]      polarity,
    output logic [N-1:0]      pwm_out,
    output logic              period_tick
);

    localparam logic [R-1:0] D_MAX = '1;
    localparam logic [R-1:0] D_ONE = R'(1);

    logic      tick;
    logic [R-1:0] d;
    logic [R-1:0] d_next;
    logic      dir;
    logic      dir_next;
    pwm_mode_e amode;
    pwm_mode_e amode_next;
    pwm_mode_e mode_in;
    logic      boundary;

    assign mode_in = pwm_mode_e'(mode);

    pwm_prescaler #(
        .DW(DW)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .dvsr (dvsr),
        .tick (tick)
    );

    // Period counter sequencing; boundary marks the tick whose next count is 0
    always_comb begin
        d_next     = d;
        dir_next   = dir;
        amode_next = amode;
        boundary   = 1'b0;
        if (!en) begin
            d_next     = '0;
            dir_next   = DIR_UP;
            amode_next = mode_in;
        end else if (tick) begin
            if (amode == PWM_EDGE) begin
                d_next   = d + D_ONE;
                boundary = (d == D_MAX);
            end else if (dir == DIR_UP) begin
                if (d == D_MAX) begin
                    d_next   = D_MAX - D_ONE;
                    dir_next = DIR_DOWN;
                end else begin
                    d_next = d + D_ONE;
                end
            end else begin
                if (d == D_ONE) begin
                    d_next   = '0;
                    dir_next = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    d_next = d - D_ONE;
                end
            end
            if (boundary) begin
                amode_next = mode_in;
                if (mode_in != amode) begin
                    dir_next = DIR_UP;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d           <= '0;
            dir         <= DIR_UP;
            amode       <= PWM_EDGE;
            period_tick <= 1'b0;
        end else begin
            d           <= d_next;
            dir         <= dir_next;
            amode       <= amode_next;
            period_tick <= boundary;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        localparam int unsigned BASE = duty_slice(i, R);

        logic [R:0] shadow;
        logic [R:0] active;
        logic       out_q;

        // Active duty only changes at a period boundary (or while idle), so no runt pulses
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                shadow <= '0;
                active <= '0;
                out_q  <= 1'b0;
            end else begin
                if (duty_wr[i]) begin
                    shadow <= duty[BASE +: R+1];
                end
                if (!en || boundary) begin
                    active <= shadow;
                end
                if (!en) begin
                    out_q <= polarity[i];
                end else begin
                    out_q <= ({1'b0, d} < active) ^ polarity[i];
                end
            end
        end

        assign pwm_out[i] = out_q;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
N-channel PWM generator with one shared prescaler and one shared period counter. It supports edge-aligned and center-aligned modes, per-channel double-buffered duty registers, and per-channel output polarity. It drives motor/LED channels on the wall-follower board. Software writes duty at any time, and the change takes effect glitch-free at the next period boundary.

Parameters:
R, 10, counter resolution in bits; MAX = 2^R-1
N, 4, channel count
DW, 32, prescaler divisor width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  run enable; 0 holds the counters at 0
mode  in  1  pwm_mode_e: 0 = PWM_EDGE, 1 = PWM_CENTER
dvsr  in  DW  prescale divisor; tick every dvsr+1 clocks; 0 means a tick every clock
duty  in  N*(R+1)  flattened duty words; channel i at [i*(R+1) +: R+1]
duty_wr  in  N  per-channel shadow write strobe
polarity  in  N  1 inverts the channel output
pwm_out  out  N  registered PWM outputs
period_tick  out  1  one-cycle registered pulse at each period boundary

Behaviour:
- Reset: all registers are 0. Applies to prescaler q, counter d, dir=up, shadow/active duty, active mode, pwm_out=0, period_tick=0.
- Prescaler: q_next = (q >= dvsr) ? 0 : q+1; tick = (q==0) && en. The >= compare makes a live dvsr decrease recover within one cycle with no 2^DW wrap.
- en=0: q, d and dir are held at 0/up. Active duty and active mode track shadow and mode every cycle. pwm_out <= polarity. period_tick = 0.
- Edge mode: on tick, d increments 0..MAX, then wraps to 0. Period = (MAX+1)*(dvsr+1) clocks.
- Center mode, on tick:
  - up: if d==MAX then d<=MAX-1, dir<=down; else d+1.
  - down: if d==1 then d<=0, dir<=up; else d-1.
  - Sequence 0,1..MAX,MAX-1..1. Period = 2*MAX ticks.
- Boundary event: a tick whose next d is 0. That is edge mode with d==MAX, or center mode with dir==down and d==1. On a boundary:
  - active duty <= shadow for all channels.
  - active mode <= mode. A mode change resets dir to up.
  - period_tick is 1 in the next cycle.
- Shadow: duty_wr[i] loads shadow[i] the next cycle. If a write and a boundary occur in the same cycle, active takes the OLD shadow, and the new value applies one period later (no bypass).
- Compare: pwm_out[i] <= ({1'b0,d} < active[i]) ^ polarity[i]. pwm_out lags d by one clock.
  - Duty 0: output constantly low (before polarity).
  - Duty >= MAX+1: output constantly high.
  - Values above MAX+1 saturate to full on.
- Center mode high time per period = 2*duty-1 ticks for 1 <= duty <= MAX.
- A reset asserted mid-period forces all state to the reset values immediately. The output restarts from d=0 after release.

Decomposition:
- Package pwm_pkg holds:
  - typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e
  - function duty_slice(i) for the flattened-bus index
- Sub-module pwm_prescaler (parameter DW): inputs clk, reset, en, dvsr; output tick. It is reusable by other timers.
- Channels are a generate loop in pwm_multi; no per-channel module.

Test Plan:
- R=4, N=2, edge, dvsr=0, en=1, duty0=4, duty1=16 -> pwm_out[0] is high 4 of every 16 clocks; pwm_out[1] is always high; period_tick every 16 clocks.
- Center mode, dvsr=0, duty0=4 -> period 30 clocks, pwm_out[0] high 7 contiguous clocks (wrapping across d=0); period_tick every 30 clocks.
- dvsr=2, edge, duty0=8 -> period 48 clocks, 24 high. Drop dvsr to 0 while q=2 -> q returns to 0 next cycle, with no long stall.
- Write duty0=12 mid-period, then write 2 on the exact boundary cycle -> the next period uses 12, and the period after uses 2. Output never shows a partial/runt pulse.
- polarity=2'b01, duty0=0 -> pwm_out[0] is constantly 1. Deassert en -> within one clock pwm_out equals polarity, period_tick stays 0.
- Assert reset mid-period with pwm_out high -> pwm_out=0 immediately (async). After release with en=1, the first high pulse starts at d=0.
